// File: rtl/register_stimulus.sv
// Drive-side sequencer for the 4-bit register harness: LOAD/SHL/SHR/ROTL/ROTR/HOLD rounds.
// Optional LFSR data source enabled by defining LFSR_DATA_EN.
module register_stimulus #(
   parameter int unsigned CYCLES_PER_PHASE = 8,
   parameter int unsigned ROUNDS           = 4,
   parameter logic [3:0]  SEED             = 4'b1011
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   output logic       ENB,
   output logic       DIR,
   output logic [1:0] MODE,
   output logic [3:0] D,
   output logic       S_IN,
   output logic [2:0] PHASE,
   output logic [3:0] ROUND,
   output logic       BUSY,
   output logic       DONE
);

   localparam int unsigned CW =
      (CYCLES_PER_PHASE > 1) ? $clog2(CYCLES_PER_PHASE) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_PHASE - 1);
   localparam logic [3:0] SEED_G = (SEED == 4'b0000) ? 4'b0001 : SEED;
   localparam logic [3:0] ROUNDS_W = 4'(ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_SHL  = 3'd2,
      S_SHR  = 3'd3,
      S_ROTL = 3'd4,
      S_ROTR = 3'd5,
      S_HOLD = 3'd6,
      S_DONE = 3'd7
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_round;
   logic [3:0]    r_data;
   logic [3:0]    r_ld;
   logic          r_enb;
   logic          r_dir;
   logic [1:0]    r_mode;
   logic [3:0]    r_d;
   logic          r_sin;
   logic          r_busy;
   logic          r_done;

   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [3:0]    w_round_nxt;
   logic [3:0]    w_round_inc;
   logic [3:0]    w_data_nxt;
   logic [3:0]    w_ld_nxt;
   logic          w_end;
   logic          w_busy_cur;
   logic          w_enb;
   logic          w_dir;
   logic [1:0]    w_mode;
   logic [3:0]    w_d;
   logic          w_sin;
   logic          w_busy;
   logic          w_done;
   logic          w_shift_bit;

   assign w_end       = (r_cnt == LAST);
   assign w_round_inc = r_round + 4'd1;
   assign w_busy_cur  = (r_state != S_IDLE) && (r_state != S_DONE);

`ifdef LFSR_DATA_EN
   // x^4+x^3+1 Fibonacci LFSR, steps every busy cycle
   always_comb begin
      w_data_nxt = r_data;
      if (w_busy_cur)
         w_data_nxt = {r_data[2:0], r_data[3] ^ r_data[2]};
   end
   assign w_shift_bit = r_data[0];
`else
   always_comb begin
      w_data_nxt = r_data;
      if (r_state == S_LOAD)
         w_data_nxt = {r_data[2:0], r_data[3]};
   end
   assign w_shift_bit = ~w_cnt_nxt[0];
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      unique case (r_state)
         S_IDLE: if (START) w_state_nxt = S_LOAD;
         S_LOAD: w_state_nxt = S_SHL;
         S_SHL:  if (w_end) w_state_nxt = S_SHR;
         S_SHR:  if (w_end) w_state_nxt = S_ROTL;
         S_ROTL: if (w_end) w_state_nxt = S_ROTR;
         S_ROTR: if (w_end) w_state_nxt = S_HOLD;
         S_HOLD: begin
            if (w_end) begin
               w_round_nxt = w_round_inc;
               w_state_nxt = (w_round_inc == ROUNDS_W) ? S_DONE : S_LOAD;
            end
         end
         S_DONE: if (!START) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_state_nxt == S_IDLE)
         w_round_nxt = 4'd0;
      if (w_state_nxt != r_state)
         w_cnt_nxt = '0;
      else if (w_busy_cur && !w_end)
         w_cnt_nxt = r_cnt + CW'(1);
      else
         w_cnt_nxt = r_cnt;
   end

   // outputs are decoded from the upcoming state so they land with it
   always_comb begin
      w_enb    = 1'b0;
      w_dir    = 1'b0;
      w_mode   = 2'b00;
      w_d      = r_ld;
      w_sin    = 1'b0;
      w_busy   = 1'b1;
      w_done   = 1'b0;
      w_ld_nxt = r_ld;
      unique case (w_state_nxt)
         S_IDLE: w_busy = 1'b0;
         S_LOAD: begin
            w_enb    = 1'b1;
            w_mode   = 2'b11;
            w_d      = r_data;
            w_ld_nxt = r_data;
         end
         S_SHL: begin
            w_enb = 1'b1;
            w_sin = w_shift_bit;
         end
         S_SHR: begin
            w_enb  = 1'b1;
            w_mode = 2'b01;
            w_sin  = w_shift_bit;
         end
         S_ROTL: begin
            w_enb  = 1'b1;
            w_mode = 2'b10;
         end
         S_ROTR: begin
            w_enb  = 1'b1;
            w_mode = 2'b10;
            w_dir  = 1'b1;
         end
         S_HOLD: begin
            w_mode = 2'b11;
            w_d    = ~r_data;
         end
         S_DONE: begin
            w_busy = 1'b0;
            w_done = 1'b1;
         end
         default: w_busy = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_round <= 4'd0;
         r_data  <= SEED_G;
         r_ld    <= 4'h0;
         r_enb   <= 1'b0;
         r_dir   <= 1'b0;
         r_mode  <= 2'b00;
         r_d     <= 4'h0;
         r_sin   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_round <= w_round_nxt;
         r_data  <= w_data_nxt;
         r_ld    <= w_ld_nxt;
         r_enb   <= w_enb;
         r_dir   <= w_dir;
         r_mode  <= w_mode;
         r_d     <= w_d;
         r_sin   <= w_sin;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign ENB   = r_enb;
   assign DIR   = r_dir;
   assign MODE  = r_mode;
   assign D     = r_d;
   assign S_IN  = r_sin;
   assign PHASE = r_state;
   assign ROUND = r_round;
   assign BUSY  = r_busy;
   assign DONE  = r_done;

endmodule
